// File: rtl/network_4.sv
// network_4: 2x2 mesh of collective reduction nodes with 1-cycle neighbour links; valid pulses 2 cycles after injection.
// No backpressure: packets failing acceptance are dropped. Define REDUCE_SATURATE_EN for saturating sums.

module network_4_node #(
  parameter int          DATA_W  = 32,
  parameter int          PKT_W   = 84,
  parameter int          COMM_W  = 50,
  parameter logic [8:0]  MY_ADDR = 9'd0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [PKT_W-1:0]        in_xpos_inject,
  input  logic [PKT_W-1:0]        in_xneg_inject,
  input  logic [PKT_W-1:0]        in_ypos_inject,
  input  logic [PKT_W-1:0]        in_yneg_inject,
  input  logic [PKT_W-1:0]        reduce_me,
  input  logic [COMM_W-1:0]       newcomm,
  input  logic [3:0][PKT_W-1:0]   rx_pkt,
  input  logic                    clr,
  output logic [3:0][PKT_W-1:0]   link_pkt,
  output logic                    done
);

  logic [3:0][PKT_W-1:0] link_q, link_d;
  logic                  comm_vld_q, comm_vld_d;
  logic [7:0]            comm_ctx_q, comm_ctx_d;
  logic [2:0]            comm_lg_q, comm_lg_d;
  logic [DATA_W-1:0]     acc_q, acc_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [7:0]            tag_q, tag_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic [4:0][PKT_W-1:0] cand;
  logic [4:0]            ok;
  logic                  found;
  logic [7:0]            tag_ref;
  logic [DATA_W+2:0]     sum;
  logic [2:0]            n_take;
  logic [3:0]            cnt_sum;
  logic                  unused_bits;

  always_comb begin
    link_d[0] = in_xpos_inject[81] ? in_xpos_inject : '0;
    link_d[1] = in_xneg_inject[81] ? in_xneg_inject : '0;
    link_d[2] = in_ypos_inject[81] ? in_ypos_inject : '0;
    link_d[3] = in_yneg_inject[81] ? in_yneg_inject : '0;

    comm_vld_d = comm_vld_q;
    comm_ctx_d = comm_ctx_q;
    comm_lg_d  = comm_lg_q;
    if (newcomm[49]) begin
      comm_vld_d = 1'b1;
      comm_ctx_d = newcomm[48:41];
      comm_lg_d  = newcomm[20:18];
    end

    // Slot 0 is the local contribution, slots 1..4 the four neighbour links.
    cand[0] = reduce_me;
    cand[1] = rx_pkt[0];
    cand[2] = rx_pkt[1];
    cand[3] = rx_pkt[2];
    cand[4] = rx_pkt[3];

    unused_bits = ^{newcomm[40:21], newcomm[17:0]};
    ok = '0;
    for (int i = 0; i < 5; i++) begin
      unused_bits = unused_bits ^ (^{cand[i][83:82], cand[i][80:54],
                                      cand[i][37:36], cand[i][33:32]});
      ok[i] = comm_vld_q && cand[i][81] &&
              (cand[i][53:46] == comm_ctx_q) && (cand[i][35:34] == 2'b11) &&
              ((i == 0) ? cand[i][83] : (cand[i][80:72] == MY_ADDR));
    end

    // An idle unit adopts the tag of the first accepted packet this cycle.
    found   = busy_q;
    tag_ref = tag_q;
    for (int i = 0; i < 5; i++) begin
      if (ok[i] && !found) begin
        found   = 1'b1;
        tag_ref = cand[i][45:38];
      end
    end

    sum    = {3'b000, acc_q};
    n_take = 3'd0;
    for (int i = 0; i < 5; i++) begin
      if (ok[i] && (cand[i][45:38] == tag_ref) && !done_q) begin
        sum    = sum + {3'b000, cand[i][DATA_W-1:0]};
        n_take = n_take + 3'd1;
      end
    end
    cnt_sum = {1'b0, cnt_q} + {1'b0, n_take};

`ifdef REDUCE_SATURATE_EN
    acc_d = (|sum[DATA_W+2:DATA_W]) ? {DATA_W{1'b1}} : sum[DATA_W-1:0];
`else
    acc_d = sum[DATA_W-1:0];
`endif
    cnt_d  = (cnt_sum > 4'd7) ? 3'd7 : cnt_sum[2:0];
    tag_d  = tag_ref;
    busy_d = busy_q || (n_take != 3'd0);
    done_d = done_q || ((n_take != 3'd0) && (cnt_sum >= ({1'b0, comm_lg_q} + 4'd1)));

    if (clr) begin
      acc_d  = '0;
      cnt_d  = '0;
      tag_d  = '0;
      busy_d = 1'b0;
      done_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      link_q     <= '0;
      comm_vld_q <= 1'b0;
      comm_ctx_q <= '0;
      comm_lg_q  <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      tag_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      link_q     <= link_d;
      comm_vld_q <= comm_vld_d;
      comm_ctx_q <= comm_ctx_d;
      comm_lg_q  <= comm_lg_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      tag_q      <= tag_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign link_pkt = link_q;
  assign done     = done_q;

endmodule

module network_4 #(
  parameter int DATA_W = 32,
  parameter int PKT_W  = 84,
  parameter int COMM_W = 50
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PKT_W-1:0]  in_xpos_inject_0_0_0,
  input  logic [PKT_W-1:0]  in_xneg_inject_0_0_0,
  input  logic [PKT_W-1:0]  in_ypos_inject_0_0_0,
  input  logic [PKT_W-1:0]  in_yneg_inject_0_0_0,
  input  logic [PKT_W-1:0]  reduce_me_0_0_0,
  input  logic [COMM_W-1:0] newcomm_0_0_0,
  input  logic [PKT_W-1:0]  in_xpos_inject_0_0_1,
  input  logic [PKT_W-1:0]  in_xneg_inject_0_0_1,
  input  logic [PKT_W-1:0]  in_ypos_inject_0_0_1,
  input  logic [PKT_W-1:0]  in_yneg_inject_0_0_1,
  input  logic [PKT_W-1:0]  reduce_me_0_0_1,
  input  logic [COMM_W-1:0] newcomm_0_0_1,
  input  logic [PKT_W-1:0]  in_xpos_inject_0_1_0,
  input  logic [PKT_W-1:0]  in_xneg_inject_0_1_0,
  input  logic [PKT_W-1:0]  in_ypos_inject_0_1_0,
  input  logic [PKT_W-1:0]  in_yneg_inject_0_1_0,
  input  logic [PKT_W-1:0]  reduce_me_0_1_0,
  input  logic [COMM_W-1:0] newcomm_0_1_0,
  input  logic [PKT_W-1:0]  in_xpos_inject_0_1_1,
  input  logic [PKT_W-1:0]  in_xneg_inject_0_1_1,
  input  logic [PKT_W-1:0]  in_ypos_inject_0_1_1,
  input  logic [PKT_W-1:0]  in_yneg_inject_0_1_1,
  input  logic [PKT_W-1:0]  reduce_me_0_1_1,
  input  logic [COMM_W-1:0] newcomm_0_1_1,
  output logic              valid
);

  logic [3:0][PKT_W-1:0] link [4];
  logic [3:0][PKT_W-1:0] rx   [4];
  logic [3:0]            done;
  logic                  valid_q, valid_d;

  // In a 2-wide mesh both pos and neg links of a dimension reach the same node.
  assign rx[0] = {link[2][3], link[2][2], link[1][1], link[1][0]};
  assign rx[1] = {link[3][3], link[3][2], link[0][1], link[0][0]};
  assign rx[2] = {link[0][3], link[0][2], link[3][1], link[3][0]};
  assign rx[3] = {link[1][3], link[1][2], link[2][1], link[2][0]};

  network_4_node #(.DATA_W(DATA_W), .PKT_W(PKT_W), .COMM_W(COMM_W), .MY_ADDR(9'd0)) u_node_0_0_0 (
    .clk(clk), .rst(rst),
    .in_xpos_inject(in_xpos_inject_0_0_0), .in_xneg_inject(in_xneg_inject_0_0_0),
    .in_ypos_inject(in_ypos_inject_0_0_0), .in_yneg_inject(in_yneg_inject_0_0_0),
    .reduce_me(reduce_me_0_0_0), .newcomm(newcomm_0_0_0),
    .rx_pkt(rx[0]), .clr(valid_q), .link_pkt(link[0]), .done(done[0])
  );

  network_4_node #(.DATA_W(DATA_W), .PKT_W(PKT_W), .COMM_W(COMM_W), .MY_ADDR(9'd1)) u_node_0_0_1 (
    .clk(clk), .rst(rst),
    .in_xpos_inject(in_xpos_inject_0_0_1), .in_xneg_inject(in_xneg_inject_0_0_1),
    .in_ypos_inject(in_ypos_inject_0_0_1), .in_yneg_inject(in_yneg_inject_0_0_1),
    .reduce_me(reduce_me_0_0_1), .newcomm(newcomm_0_0_1),
    .rx_pkt(rx[1]), .clr(valid_q), .link_pkt(link[1]), .done(done[1])
  );

  network_4_node #(.DATA_W(DATA_W), .PKT_W(PKT_W), .COMM_W(COMM_W), .MY_ADDR(9'd8)) u_node_0_1_0 (
    .clk(clk), .rst(rst),
    .in_xpos_inject(in_xpos_inject_0_1_0), .in_xneg_inject(in_xneg_inject_0_1_0),
    .in_ypos_inject(in_ypos_inject_0_1_0), .in_yneg_inject(in_yneg_inject_0_1_0),
    .reduce_me(reduce_me_0_1_0), .newcomm(newcomm_0_1_0),
    .rx_pkt(rx[2]), .clr(valid_q), .link_pkt(link[2]), .done(done[2])
  );

  network_4_node #(.DATA_W(DATA_W), .PKT_W(PKT_W), .COMM_W(COMM_W), .MY_ADDR(9'd9)) u_node_0_1_1 (
    .clk(clk), .rst(rst),
    .in_xpos_inject(in_xpos_inject_0_1_1), .in_xneg_inject(in_xneg_inject_0_1_1),
    .in_ypos_inject(in_ypos_inject_0_1_1), .in_yneg_inject(in_yneg_inject_0_1_1),
    .reduce_me(reduce_me_0_1_1), .newcomm(newcomm_0_1_1),
    .rx_pkt(rx[3]), .clr(valid_q), .link_pkt(link[3]), .done(done[3])
  );

  // Done flags stay up through the pulse cycle; masking with valid_q keeps it one cycle.
  always_comb begin
    valid_d = (&done) && !valid_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
  end

  assign valid = valid_q;

endmodule

// File: tb/tb_network_4.sv
// Directed bench for network_4: full reductions, missing contribution, context/opcode filtering, mid-run reset, overflow.
module tb_network_4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [83:0] xpos_i [4];
  logic [83:0] xneg_i [4];
  logic [83:0] ypos_i [4];
  logic [83:0] yneg_i [4];
  logic [83:0] rme_i  [4];
  logic [49:0] comm_i [4];
  logic        valid;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] acc_w [4];
  logic [2:0]  cnt_w [4];
  assign acc_w[0] = dut.u_node_0_0_0.acc_q;
  assign acc_w[1] = dut.u_node_0_0_1.acc_q;
  assign acc_w[2] = dut.u_node_0_1_0.acc_q;
  assign acc_w[3] = dut.u_node_0_1_1.acc_q;
  assign cnt_w[0] = dut.u_node_0_0_0.cnt_q;
  assign cnt_w[1] = dut.u_node_0_0_1.cnt_q;
  assign cnt_w[2] = dut.u_node_0_1_0.cnt_q;
  assign cnt_w[3] = dut.u_node_0_1_1.cnt_q;

  network_4 dut (
    .clk(clk), .rst(rst),
    .in_xpos_inject_0_0_0(xpos_i[0]), .in_xneg_inject_0_0_0(xneg_i[0]),
    .in_ypos_inject_0_0_0(ypos_i[0]), .in_yneg_inject_0_0_0(yneg_i[0]),
    .reduce_me_0_0_0(rme_i[0]), .newcomm_0_0_0(comm_i[0]),
    .in_xpos_inject_0_0_1(xpos_i[1]), .in_xneg_inject_0_0_1(xneg_i[1]),
    .in_ypos_inject_0_0_1(ypos_i[1]), .in_yneg_inject_0_0_1(yneg_i[1]),
    .reduce_me_0_0_1(rme_i[1]), .newcomm_0_0_1(comm_i[1]),
    .in_xpos_inject_0_1_0(xpos_i[2]), .in_xneg_inject_0_1_0(xneg_i[2]),
    .in_ypos_inject_0_1_0(ypos_i[2]), .in_yneg_inject_0_1_0(yneg_i[2]),
    .reduce_me_0_1_0(rme_i[2]), .newcomm_0_1_0(comm_i[2]),
    .in_xpos_inject_0_1_1(xpos_i[3]), .in_xneg_inject_0_1_1(xneg_i[3]),
    .in_ypos_inject_0_1_1(ypos_i[3]), .in_yneg_inject_0_1_1(yneg_i[3]),
    .reduce_me_0_1_1(rme_i[3]), .newcomm_0_1_1(comm_i[3]),
    .valid(valid)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Node k sits at y=k[1], x=k[0]; address {z,y,x} gives 0,1,8,9.
  function automatic logic [8:0] addr_of(input int k);
    logic [1:0] kb;
    kb = k[1:0];
    return {3'b000, 2'b00, kb[1], 2'b00, kb[0]};
  endfunction

  function automatic logic [83:0] mk_pkt(input logic loc, input logic [8:0] dst, input logic [8:0] src,
                                         input logic [7:0] ctx, input logic [3:0] op,
                                         input logic [31:0] pay);
    return {loc, 1'b0, 1'b1, dst, src, 9'd0, ctx, 8'd0, 2'b00, op, pay};
  endfunction

  function automatic logic [49:0] mk_comm(input logic [8:0] rank, input logic [8:0] p2, input logic [8:0] p1);
    return {1'b1, 8'd0, 9'd0, rank, 2'b00, 3'd2, p2, p1};
  endfunction

  task automatic idle();
    for (int k = 0; k < 4; k++) begin
      xpos_i[k] = '0; xneg_i[k] = '0; ypos_i[k] = '0; yneg_i[k] = '0; rme_i[k] = '0;
    end
  endtask

  // Drives one round at a negedge; returns just after the injection edge with inputs idled.
  task automatic inject(input logic [7:0] ctx, input logic [3:0] op, input logic [31:0] pay, input int skip_y);
    for (int k = 0; k < 4; k++) begin
      rme_i[k]  = mk_pkt(1'b1, addr_of(k), addr_of(k), ctx, op, pay);
      xpos_i[k] = mk_pkt(1'b0, addr_of(k ^ 1), addr_of(k), ctx, op, pay);
      ypos_i[k] = (k == skip_y) ? '0 : mk_pkt(1'b0, addr_of(k ^ 2), addr_of(k), ctx, op, pay);
    end
    @(negedge clk);
    idle();
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    @(negedge clk);
    check("valid_in_reset", {31'd0, valid}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("valid_after_reset", {31'd0, valid}, 32'd0);
  endtask

  task automatic quiet_watch(input string nm, input int cycles);
    int highs;
    highs = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (valid) highs++;
    end
    check(nm, highs, 0);
  endtask

  task automatic full_round(input string nm, input logic [31:0] pay, input logic [31:0] exp_acc);
    inject(8'd0, 4'b1110, pay, -1);
    check({nm, "_valid_e0"}, {31'd0, valid}, 32'd0);
    @(negedge clk);
    check({nm, "_valid_e1"}, {31'd0, valid}, 32'd0);
    @(negedge clk);
    check({nm, "_valid_e2"}, {31'd0, valid}, 32'd1);
    for (int k = 0; k < 4; k++) check($sformatf("%s_acc%0d", nm, k), acc_w[k], exp_acc);
    @(negedge clk);
    check({nm, "_valid_e3"}, {31'd0, valid}, 32'd0);
    check({nm, "_acc_cleared"}, acc_w[0], 32'd0);
    check({nm, "_cnt_cleared"}, {29'd0, cnt_w[3]}, 32'd0);
    quiet_watch({nm, "_no_repeat"}, 6);
  endtask

  initial begin
    logic [31:0] sat_exp;
    rst = 1'b1;
    idle();
    comm_i[0] = mk_comm(9'd0, 9'd2, 9'd1);
    comm_i[1] = mk_comm(9'd1, 9'd3, 9'd0);
    comm_i[2] = mk_comm(9'd2, 9'd0, 9'd3);
    comm_i[3] = mk_comm(9'd3, 9'd1, 9'd2);
    @(negedge clk);
    @(negedge clk);
    check("reset_valid", {31'd0, valid}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("first_cycle_valid", {31'd0, valid}, 32'd0);
    check("reset_acc", acc_w[0], 32'd0);
    check("reset_cnt", {29'd0, cnt_w[2]}, 32'd0);

    // Full all-reduce: 6 local + 6 from x neighbour + 6 from y neighbour.
    full_round("allred", 32'd6, 32'd18);

    // Node 0_1_1 withholds its y packet, so its y neighbour 0_0_1 stalls at 2.
    reset_dut();
    inject(8'd0, 4'b1110, 32'd6, 3);
    quiet_watch("missing_y_valid", 6);
    check("missing_y_cnt1", {29'd0, cnt_w[1]}, 32'd2);
    check("missing_y_cnt0", {29'd0, cnt_w[0]}, 32'd3);

    // Context mismatch: everything dropped.
    reset_dut();
    inject(8'd1, 4'b1110, 32'd6, -1);
    quiet_watch("bad_ctx_valid", 6);
    check("bad_ctx_cnt", {29'd0, cnt_w[0]}, 32'd0);

    // Broadcast opcode is not a reduction.
    reset_dut();
    inject(8'd0, 4'b0111, 32'd6, -1);
    quiet_watch("bcast_valid", 6);
    check("bcast_cnt", {29'd0, cnt_w[1]}, 32'd0);
    check("bcast_acc", acc_w[1], 32'd0);

    // Reset between injection and completion.
    reset_dut();
    inject(8'd0, 4'b1110, 32'd6, -1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_valid", {31'd0, valid}, 32'd0);
    check("midrst_acc", acc_w[2], 32'd0);
    rst = 1'b0;
    quiet_watch("midrst_quiet", 6);
    full_round("after_rst", 32'd6, 32'd18);

    // Three all-ones contributions per node.
    reset_dut();
`ifdef REDUCE_SATURATE_EN
    sat_exp = 32'hFFFF_FFFF;
`else
    sat_exp = 32'hFFFF_FFFD;
`endif
    full_round("overflow", 32'hFFFF_FFFF, sat_exp);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
